// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers for the flip-flop FIFO and its pointer counters.
package fifo_pkg;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping 0..DEPTH-1 pointer; explicit terminal compare so DEPTH need not be a power of two.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    output logic [ptr_width(DEPTH)-1:0] ptr
);

    localparam int PW = ptr_width(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end

endmodule

// File: rtl/fifo_ff.sv
// fifo_ff: single-clock register-array FIFO with first-word-fall-through read data
// and registered full/empty/occupancy status.
module fifo_ff
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [occ_width(DEPTH)-1:0] occup
);

    localparam int PW = ptr_width(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    occ_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // a full FIFO never forwards a write into the slot being read
    assign wr_acc = wr_en & ~full & ~rst;
    assign rd_acc = rd_en & ~empty & ~rst;

    assign occ_nxt = (wr_acc && !rd_acc) ? occup + OW'(1) :
                     (rd_acc && !wr_acc) ? occup - OW'(1) : occup;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_acc),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occup <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            occup <= occ_nxt;
            full  <= (occ_nxt == OW'(DEPTH));
            empty <= (occ_nxt == '0);
        end
    end

    // storage is never reset, so mask it while nothing valid is at the head
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_fifo_ff.sv
// tb_fifo_ff: directed and random checks of fifo_ff against a queue-based model,
// on a main instance and a non-power-of-two DEPTH=5 instance.
module tb_fifo_ff;

    parameter int FIFO_FF_DUT_WIDTH = 8;
    parameter int FIFO_FF_DUT_DEPTH = 8;

    localparam int W   = FIFO_FF_DUT_WIDTH;
    localparam int D   = FIFO_FF_DUT_DEPTH;
    localparam int OW  = $clog2(D) + 1;
    localparam int D5  = 5;
    localparam int OW5 = $clog2(D5) + 1;

    logic           clk;
    logic           rst;
    logic           wr_en, rd_en, full, empty;
    logic [W-1:0]   wr_data, rd_data;
    logic [OW-1:0]  occup;
    logic           wr_en5, rd_en5, full5, empty5;
    logic [W-1:0]   wr_data5, rd_data5;
    logic [OW5-1:0] occup5;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q8[$];
    logic [W-1:0] q5[$];

    fifo_ff #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .occup   (occup)
    );

    fifo_ff #(.WIDTH(W), .DEPTH(D5)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en5),
        .wr_data (wr_data5),
        .rd_en   (rd_en5),
        .rd_data (rd_data5),
        .full    (full5),
        .empty   (empty5),
        .occup   (occup5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic verify(input int sel, input string tag);
        if (sel == 0) begin
            check({tag, ":occup"}, 64'(occup), 64'(q8.size()));
            check({tag, ":empty"}, 64'(empty), 64'(q8.size() == 0));
            check({tag, ":full"}, 64'(full), 64'(q8.size() == D));
            check({tag, ":rd_data"}, 64'(rd_data), 64'(q8.size() ? q8[0] : '0));
        end else begin
            check({tag, ":occup"}, 64'(occup5), 64'(q5.size()));
            check({tag, ":empty"}, 64'(empty5), 64'(q5.size() == 0));
            check({tag, ":full"}, 64'(full5), 64'(q5.size() == D5));
            check({tag, ":rd_data"}, 64'(rd_data5), 64'(q5.size() ? q5[0] : '0));
        end
    endtask

    // One clock with the given request; the model applies the acceptance rules to its pre-edge occupancy.
    task automatic step(input int sel, input bit we, input bit re, input logic [W-1:0] d, input string tag);
        bit wa, ra;
        if (sel == 0) begin
            wr_en = we; rd_en = re; wr_data = d;
        end else begin
            wr_en5 = we; rd_en5 = re; wr_data5 = d;
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            wa = we && q8.size() < D;
            ra = re && q8.size() != 0;
            if (ra) void'(q8.pop_front());
            if (wa) q8.push_back(d);
            wr_en = 1'b0; rd_en = 1'b0;
        end else begin
            wa = we && q5.size() < D5;
            ra = re && q5.size() != 0;
            if (ra) void'(q5.pop_front());
            if (wa) q5.push_back(d);
            wr_en5 = 1'b0; rd_en5 = 1'b0;
        end
        verify(sel, tag);
    endtask

    initial begin
        int written, readn, cyc;
        logic [W-1:0] d;
        rst = 1'b1;
        wr_en = 0; rd_en = 0; wr_data = '0;
        wr_en5 = 0; rd_en5 = 0; wr_data5 = '0;
        repeat (2) @(posedge clk);
        #1;
        verify(0, "reset");
        verify(1, "reset5");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < D; i++) step(0, 1, 0, W'(i + 1), "fill");
        check("fill_full", 64'(full), 64'(1));
        step(0, 1, 0, '1, "overflow");
        for (int i = 0; i < D; i++) begin
            check("drain_order", 64'(rd_data), 64'(W'(i + 1)));
            step(0, 0, 1, '0, "drain");
        end
        check("drain_empty", 64'(empty), 64'(1));

        step(0, 1, 0, W'(8'hA5), "fwft");
        check("fwft_data", 64'(rd_data), 64'(W'(8'hA5)));
        step(0, 0, 1, '0, "fwft_pop");

        for (int i = 0; i < 3; i++) step(0, 1, 0, W'($urandom), "pre3");
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, W'($urandom), "both_mid");
            check("both_mid_occ3", 64'(occup), 64'(3));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, '0, "drain3");

        step(0, 1, 1, W'(8'h3C), "both_empty");
        check("both_empty_occ1", 64'(occup), 64'(1));
        for (int i = 1; i < D; i++) step(0, 1, 0, W'($urandom), "refill");
        step(0, 1, 1, W'(8'hEE), "both_full");
        check("both_full_occ", 64'(occup), 64'(D - 1));
        for (int i = 0; i < D; i++) step(0, 1, 1, W'($urandom), "churn");

        while (q8.size() > 5) step(0, 0, 1, '0, "to5");
        while (q8.size() < 5) step(0, 1, 0, W'($urandom), "to5");
        check("pre_reset_occ5", 64'(occup), 64'(5));
        wr_en = 1'b1; rd_en = 1'b1; wr_data = W'($urandom);
        #2;
        rst = 1'b1;
        #1;
        q8.delete();
        q5.delete();
        verify(0, "async_reset");
        @(posedge clk);
        #1;
        verify(0, "reset_hold");
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        step(1, 0, 1, '0, "underflow5");
        step(1, 0, 1, '0, "underflow5b");
        step(1, 1, 0, W'(8'h11), "after_underflow5");
        step(1, 0, 1, '0, "after_underflow5_pop");

        written = 0; readn = 0; cyc = 0;
        while (readn < 20 && cyc < 1000) begin
            bit we, re;
            we = (written < 20) && $urandom_range(0, 1) == 1;
            re = $urandom_range(0, 2) != 0 && cyc % 7 != 0;
            d  = W'($urandom);
            if (we && q5.size() < D5) written++;
            if (re && q5.size() != 0) readn++;
            step(1, we, re, d, "stream5");
            check("stream5_occ_le5", 64'(occup5 <= OW5'(D5)), 64'(1));
            cyc++;
        end
        check("stream5_count", 64'(readn), 64'(20));
        check("stream5_done_empty", 64'(empty5), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
